// File: rtl/spi_rx_sync.sv
// -----------------------------------------------------------------------------
// spi_rx_sync
//   SPI receive front end running entirely in the system clock domain.
//   The raw SPI lines are synchronised, sclk rising edges are detected by
//   comparing against the previous synchronised value, and MSB-first words
//   are shifted in. Completed words are queued in a small FIFO and offered on
//   a valid/ready interface. sclk is never used as a clock.
//
//   Optional build macro: SPI_RX_STATS_EN adds o_frame_cnt, a wrapping
//   16-bit count of cleanly terminated frames that carried at least one word.
//
// Ports:
//   i_clk        system clock
//   i_rst        synchronous active-high reset
//   i_sclk       SPI serial clock (asynchronous to i_clk)
//   i_mosi       SPI serial data
//   i_cs         SPI chip select, active-low
//   o_rx_data    FIFO head word (meaningful while o_rx_valid=1)
//   o_rx_valid   FIFO non-empty
//   i_rx_ready   consumer accepts o_rx_data this cycle
//   o_overrun    one-cycle pulse: completed word dropped, FIFO full
//   o_frame_err  one-cycle pulse: frame aborted or start bit invalid
//   o_rx_busy    frame in progress
//   o_frame_cnt  clean frame count (only with SPI_RX_STATS_EN)
// -----------------------------------------------------------------------------
module spi_rx_sync #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int START_BIT   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sclk,
  input  logic              i_mosi,
  input  logic              i_cs,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_rx_ready,
  output logic              o_overrun,
  output logic              o_frame_err,
  output logic              o_rx_busy
`ifdef SPI_RX_STATS_EN
  ,
  output logic [15:0]       o_frame_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_WAIT_CS = 2'd3
  } state_t;

  // Synchroniser chains and edge-detect history
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync;
  logic                   r_sclk_prev, r_cs_prev;
  logic                   w_s_sclk, w_s_mosi, w_s_cs;
  logic                   w_rise, w_cs_fall;

  // FSM and deserialiser
  state_t                 r_state, w_state_next;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [DATA_W-1:0]      r_shreg;
  logic                   w_shift_en, w_word_done, w_frame_err;
  logic                   r_wr_req;
  logic [DATA_W-1:0]      r_wr_data;
  logic                   r_frame_err, r_rx_busy;

  // FIFO
  logic [DATA_W-1:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr, w_rd_next;
  logic [PTR_W:0]         r_count, w_cnt_after_pop;
  logic                   w_pop, w_full, w_push, w_drop;
  logic                   r_rx_valid, r_overrun;
  logic [DATA_W-1:0]      r_rx_data;

  assign w_s_sclk  = r_sclk_sync[SYNC_STAGES-1];
  assign w_s_mosi  = r_mosi_sync[SYNC_STAGES-1];
  assign w_s_cs    = r_cs_sync[SYNC_STAGES-1];
  // A rising edge coinciding with cs high is discarded so the cs rise wins.
  assign w_rise    = w_s_sclk & ~r_sclk_prev & ~w_s_cs;
  assign w_cs_fall = r_cs_prev & ~w_s_cs;

  // Synchronise the SPI lines and keep one cycle of history for edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sclk_sync <= {SYNC_STAGES{1'b0}};
      r_mosi_sync <= {SYNC_STAGES{1'b0}};
      r_cs_sync   <= {SYNC_STAGES{1'b1}};
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
      r_sclk_prev <= w_s_sclk;
      r_cs_prev   <= w_s_cs;
    end
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_state_next = (START_BIT != 0) ? ST_START : ST_SHIFT;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_s_cs) begin
          w_state_next = ST_IDLE;
        end else if (w_rise) begin
          w_state_next = w_s_mosi ? ST_SHIFT : ST_WAIT_CS;
        end else begin
          w_state_next = ST_START;
        end
      end
      ST_SHIFT: begin
        if (w_s_cs) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_SHIFT;
        end
      end
      ST_WAIT_CS: begin
        if (w_s_cs) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_WAIT_CS;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: shift strobe, word completion and error detection
  always_comb begin
    w_shift_en  = 1'b0;
    w_word_done = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      ST_START: begin
        w_frame_err = w_rise & ~w_s_mosi;
      end
      ST_SHIFT: begin
        w_shift_en  = w_rise;
        w_word_done = w_rise & (r_bit_cnt == LAST_BIT);
        w_frame_err = w_s_cs & (r_bit_cnt != {CNT_W{1'b0}});
      end
      default: begin
        w_shift_en  = 1'b0;
        w_word_done = 1'b0;
        w_frame_err = 1'b0;
      end
    endcase
  end

  // Deserialiser, FIFO write request and registered status outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shreg     <= {DATA_W{1'b0}};
      r_bit_cnt   <= {CNT_W{1'b0}};
      r_wr_req    <= 1'b0;
      r_wr_data   <= {DATA_W{1'b0}};
      r_frame_err <= 1'b0;
      r_rx_busy   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      r_rx_busy   <= (w_state_next != ST_IDLE);
      r_wr_req    <= w_word_done;
      if (w_word_done) begin
        r_wr_data <= {r_shreg[DATA_W-2:0], w_s_mosi};
      end
      // Leaving or not yet in SHIFT discards any partial word.
      if (w_state_next != ST_SHIFT) begin
        r_shreg   <= {DATA_W{1'b0}};
        r_bit_cnt <= {CNT_W{1'b0}};
      end else if (w_shift_en) begin
        r_shreg   <= {r_shreg[DATA_W-2:0], w_s_mosi};
        r_bit_cnt <= w_word_done ? {CNT_W{1'b0}} : r_bit_cnt + CNT_W'(1);
      end
    end
  end

  assign w_pop           = r_rx_valid & i_rx_ready;
  assign w_full          = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_push          = r_wr_req & (~w_full | w_pop);
  assign w_drop          = r_wr_req & w_full & ~w_pop;
  assign w_rd_next       = r_rd_ptr + PTR_W'(w_pop);
  // Valid and head data look only at the pop, so a new write becomes visible
  // one cycle after it lands and a popped entry is never presented twice.
  assign w_cnt_after_pop = r_count - (PTR_W+1)'(w_pop);

  // Receive FIFO storage, pointers and registered head/valid/overrun
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_count    <= {(PTR_W+1){1'b0}};
      r_rx_valid <= 1'b0;
      r_rx_data  <= {DATA_W{1'b0}};
      r_overrun  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_wr_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr   <= w_rd_next;
      r_count    <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
      r_rx_valid <= (w_cnt_after_pop != {(PTR_W+1){1'b0}});
      r_rx_data  <= r_mem[w_rd_next];
      r_overrun  <= w_drop;
    end
  end

  assign o_rx_data   = r_rx_data;
  assign o_rx_valid  = r_rx_valid;
  assign o_overrun   = r_overrun;
  assign o_frame_err = r_frame_err;
  assign o_rx_busy   = r_rx_busy;

`ifdef SPI_RX_STATS_EN
  logic        r_word_seen;
  logic        w_clean_end;
  logic [15:0] r_frame_cnt;

  assign w_clean_end = (r_state == ST_SHIFT) & w_s_cs &
                       (r_bit_cnt == {CNT_W{1'b0}}) & r_word_seen;

  // Track whether the current frame delivered a word and count clean frame ends
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_word_seen <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      if (w_state_next == ST_IDLE) begin
        r_word_seen <= 1'b0;
      end else if (w_word_done) begin
        r_word_seen <= 1'b1;
      end
      if (w_clean_end) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign o_frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_spi_rx_sync.sv
// -----------------------------------------------------------------------------
// tb_spi_rx_sync
//   Directed bench for spi_rx_sync at default parameters. Each task drives one
//   scenario with an SPI bit-banger (8 clk per sclk phase) and checks the
//   outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_spi_rx_sync;

  localparam int PH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       cs = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;
  logic       rx_busy;
`ifdef SPI_RX_STATS_EN
  logic [15:0] frame_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int err_cycles = 0;
  int ovr_cycles = 0;
  logic [7:0] popq[$];

  spi_rx_sync dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_sclk      (sclk),
    .i_mosi      (mosi),
    .i_cs        (cs),
    .o_rx_data   (rx_data),
    .o_rx_valid  (rx_valid),
    .i_rx_ready  (rx_ready),
    .o_overrun   (overrun),
    .o_frame_err (frame_err),
    .o_rx_busy   (rx_busy)
`ifdef SPI_RX_STATS_EN
    ,
    .o_frame_cnt (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Pulse and pop monitor, sampled mid-cycle
  always @(negedge clk) begin
    #1;
    if (frame_err === 1'b1) err_cycles++;
    if (overrun === 1'b1) ovr_cycles++;
    if (!rst && rx_valid === 1'b1 && rx_ready === 1'b1) popq.push_back(rx_data);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    mosi = b;
    sclk = 1'b0;
    tick(PH);
    sclk = 1'b1;
    tick(PH);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic cs_start();
    cs = 1'b0;
    tick(PH);
  endtask

  task automatic cs_end();
    tick(PH);
    cs = 1'b1;
    tick(3 * PH);
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    tick(12);
    rx_ready = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(1);
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rx_valid); end
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", rx_data); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    n_tests++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", rx_busy); end
`ifdef SPI_RX_STATS_EN
    n_tests++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
`endif
  endtask

  task automatic test_single();
    int e0;
    e0 = err_cycles;
    rx_ready = 1'b0;
    cs_start();
    send_bit(1'b1);
    send_byte(8'h18);
    cs_end();
    n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", rx_valid); end
    n_tests++; if (rx_data !== 8'h18) begin n_fail++; $display("FAIL single_data got %h want 18", rx_data); end
    n_tests++; if (err_cycles - e0 != 0) begin n_fail++; $display("FAIL single_err got %0d want 0", err_cycles - e0); end
    n_tests++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy got %b want 0", rx_busy); end
`ifdef SPI_RX_STATS_EN
    n_tests++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL single_frame_cnt got %0d want 1", frame_cnt); end
`endif
    drain();
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained got %b want 0", rx_valid); end
  endtask

  task automatic test_latency();
    logic [7:0] b;
    int lat;
    b = 8'h5A;
    lat = 0;
    cs_start();
    send_bit(1'b1);
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
    mosi = b[0];
    tick(PH);
    sclk = 1'b1;
    for (int k = 1; k <= PH; k++) begin
      tick(1);
      if (lat == 0 && rx_valid === 1'b1) lat = k;
    end
    sclk = 1'b0;
    cs_end();
    n_tests++; if (lat != 5) begin n_fail++; $display("FAIL latency got %0d want 5", lat); end
    n_tests++; if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL latency_data got %h want 5a", rx_data); end
    drain();
  endtask

  task automatic test_back_to_back();
    int q0, e0;
    logic [7:0] g0, g1;
    q0 = popq.size();
    e0 = err_cycles;
    rx_ready = 1'b1;
    cs_start();
    send_bit(1'b1);
    send_byte(8'hA5);
    send_byte(8'h3C);
    cs_end();
    rx_ready = 1'b0;
    tick(2);
    g0 = (popq.size() > q0) ? popq[q0] : 8'hxx;
    g1 = (popq.size() > q0 + 1) ? popq[q0+1] : 8'hxx;
    n_tests++; if (popq.size() - q0 != 2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", popq.size() - q0); end
    n_tests++; if (g0 !== 8'hA5) begin n_fail++; $display("FAIL b2b_first got %h want a5", g0); end
    n_tests++; if (g1 !== 8'h3C) begin n_fail++; $display("FAIL b2b_second got %h want 3c", g1); end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid got %b want 0", rx_valid); end
    n_tests++; if (err_cycles - e0 != 0) begin n_fail++; $display("FAIL b2b_err got %0d want 0", err_cycles - e0); end
  endtask

  task automatic test_overrun();
    int o0, q0;
    logic [7:0] g;
    o0 = ovr_cycles;
    rx_ready = 1'b0;
    cs_start();
    send_bit(1'b1);
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    cs_end();
    n_tests++; if (ovr_cycles - o0 != 1) begin n_fail++; $display("FAIL overrun_pulse got %0d want 1", ovr_cycles - o0); end
    n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_valid got %b want 1", rx_valid); end
    n_tests++; if (rx_data !== 8'h01) begin n_fail++; $display("FAIL overrun_head got %h want 01", rx_data); end
    q0 = popq.size();
    drain();
    n_tests++; if (popq.size() - q0 != 4) begin n_fail++; $display("FAIL overrun_pops got %0d want 4", popq.size() - q0); end
    for (int i = 0; i < 4; i++) begin
      g = (popq.size() > q0 + i) ? popq[q0+i] : 8'hxx;
      n_tests++; if (g !== 8'(i + 1)) begin n_fail++; $display("FAIL overrun_pop%0d got %h want %h", i, g, 8'(i + 1)); end
    end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_empty got %b want 0", rx_valid); end
  endtask

  task automatic test_abort();
    int e0;
    e0 = err_cycles;
    rx_ready = 1'b0;
    cs_start();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    cs_end();
    n_tests++; if (err_cycles - e0 != 1) begin n_fail++; $display("FAIL abort_err got %0d want 1", err_cycles - e0); end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b want 0", rx_valid); end
    cs_start();
    send_bit(1'b1);
    send_byte(8'h7E);
    cs_end();
    n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL abort_next_valid got %b want 1", rx_valid); end
    n_tests++; if (rx_data !== 8'h7E) begin n_fail++; $display("FAIL abort_next_data got %h want 7e", rx_data); end
    n_tests++; if (err_cycles - e0 != 1) begin n_fail++; $display("FAIL abort_next_err got %0d want 1", err_cycles - e0); end
`ifdef SPI_RX_STATS_EN
    n_tests++; if (frame_cnt !== 16'd5) begin n_fail++; $display("FAIL abort_frame_cnt got %0d want 5", frame_cnt); end
`endif
    drain();
  endtask

  task automatic test_bad_start();
    int e0;
    e0 = err_cycles;
    rx_ready = 1'b0;
    cs_start();
    send_bit(1'b0);
    send_byte(8'hFF);
    n_tests++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL badstart_busy got %b want 1", rx_busy); end
    cs_end();
    n_tests++; if (err_cycles - e0 != 1) begin n_fail++; $display("FAIL badstart_err got %0d want 1", err_cycles - e0); end
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL badstart_valid got %b want 0", rx_valid); end
    n_tests++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL badstart_idle got %b want 0", rx_busy); end
`ifdef SPI_RX_STATS_EN
    n_tests++; if (frame_cnt !== 16'd5) begin n_fail++; $display("FAIL badstart_frame_cnt got %0d want 5", frame_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    int e0;
    rx_ready = 1'b0;
    cs_start();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    e0 = err_cycles;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    cs = 1'b1;
    n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", rx_valid); end
    n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_data got %h want 00", rx_data); end
    n_tests++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", rx_busy); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_err got %b want 0", frame_err); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_overrun got %b want 0", overrun); end
`ifdef SPI_RX_STATS_EN
    n_tests++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_frame_cnt got %0d want 0", frame_cnt); end
`endif
    tick(3 * PH);
    cs_start();
    send_bit(1'b1);
    send_byte(8'hC3);
    cs_end();
    n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_next_valid got %b want 1", rx_valid); end
    n_tests++; if (rx_data !== 8'hC3) begin n_fail++; $display("FAIL rstmid_next_data got %h want c3", rx_data); end
    n_tests++; if (err_cycles - e0 != 0) begin n_fail++; $display("FAIL rstmid_next_err got %0d want 0", err_cycles - e0); end
`ifdef SPI_RX_STATS_EN
    n_tests++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL rstmid_next_frame_cnt got %0d want 1", frame_cnt); end
`endif
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_latency();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_bad_start();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_rx_sync.md
Name: spi_rx_sync

Overview:
- Downstream consumer of the SPI master's serial outputs (sclk, mosi, cs).
- Runs entirely in the system clock domain; it does not use sclk as a clock.
- Synchronises the three SPI lines, detects sclk rising edges, and deserialises MSB-first bytes.
- Buffers received bytes in a small FIFO and presents them on a valid/ready interface to the next stage.

Parameters:
- DATA_W, 8: bits per received word.
- FIFO_DEPTH, 4: receive FIFO entries. Must be a power of two, minimum 2.
- SYNC_STAGES, 2: flop stages on each of sclk, mosi, cs. Minimum 2.
- START_BIT, 1: when 1, the first sampled bit of each frame is a start bit that must equal 1 and is discarded. When 0, no start bit.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous and active-high
- sclk  in  1  SPI serial clock from master (asynchronous to clk)
- mosi  in  1  SPI serial data from master
- cs  in  1  SPI chip select, active-low
- rx_data  out  DATA_W  FIFO head word
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  consumer accepts rx_data this cycle
- overrun  out  1  one-cycle pulse: completed word dropped because FIFO full
- frame_err  out  1  one-cycle pulse: frame aborted or start bit invalid
- rx_busy  out  1  high while a frame is in progress (FSM not IDLE)

Behaviour:
- Reset:
  - Applied on the rst edge at posedge clk.
  - Synchroniser chains load idle values: sclk=0, mosi=0, cs=1.
  - FSM goes to IDLE; bit counter and shift register clear; FIFO empties.
  - Outputs: rx_valid=0, rx_data=0, overrun=0, frame_err=0, rx_busy=0.
  - Reset mid-frame discards the partial word with no error pulse.
- Synchronisation and edge detection:
  - s_sclk, s_mosi, s_cs are the last stage of each chain.
  - A rising edge is detected when s_sclk=1 and its previous registered value was 0.
  - Edges are honoured only while s_cs=0.
  - sclk high and low phases must each be at least 2 clk cycles; shorter phases are out of spec.
- FSM states:
  - IDLE:
    - s_cs falling (1→0) moves to START if START_BIT=1, else to SHIFT.
  - START:
    - On the first rising edge: s_mosi=1 moves to SHIFT.
    - On the first rising edge: s_mosi=0 pulses frame_err and moves to WAIT_CS.
    - s_cs=1 before any edge returns to IDLE with no error.
  - SHIFT:
    - Each rising edge does shreg <= {shreg[DATA_W-2:0], s_mosi} and bit_cnt+1.
    - On the DATA_W-th edge: write the word to the FIFO, set bit_cnt=0, stay in SHIFT. Back-to-back words are allowed within one frame with no repeated start bit.
    - s_cs=1 with bit_cnt=0 returns to IDLE (clean end).
    - s_cs=1 with bit_cnt≠0 pulses frame_err, discards the partial word, and returns to IDLE.
  - WAIT_CS:
    - Ignore all edges until s_cs=1, then return to IDLE.
  - Same-cycle event: if s_cs rises in the same cycle as a rising edge, the edge is ignored and the cs rise takes priority.
- FIFO:
  - Write occurs in the cycle after the completing edge is detected.
  - rx_valid rises on the following clk (registered count).
  - rx_data is the registered head word, valid whenever rx_valid=1.
  - Pop occurs on rx_valid && rx_ready.
  - Write when full with no pop in the same cycle: word dropped, overrun pulses for 1 cycle, FIFO contents unchanged.
  - Write and pop in the same cycle when full: both succeed; no overrun.
  - Write and pop in the same cycle when empty: no pass-through; rx_valid rises the next cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Latency:
  - From the raw sclk rising edge to rx_valid=1 is SYNC_STAGES+3 clk cycles (5 at defaults).
- rx_busy is 1 in START, SHIFT and WAIT_CS.

Optional Feature:
- Macro: SPI_RX_STATS_EN.
- When defined:
  - Adds output frame_cnt[15:0], reset to 0.
  - Increments by 1 (wrapping 0xFFFF→0) on each clean frame end: SHIFT→IDLE with bit_cnt=0 and at least one word received.
  - Aborted frames and frames with an invalid start bit do not count.
- When undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- START_BIT=1, cs low, send start bit then 0x18 MSB-first (8 clk per sclk phase), cs high → rx_valid=1, rx_data=0x18, frame_err=0. With SPI_RX_STATS_EN, frame_cnt=1.
- One cs frame carrying 0xA5 then 0x3C, rx_ready=1 → two pops in order 0xA5, 0x3C; rx_valid=0 afterwards.
- rx_ready=0, send 0x01..0x05 → FIFO holds 0x01..0x04; overrun pulses exactly once on 0x05. Raise rx_ready → pops 0x01, 0x02, 0x03, 0x04.
- cs raised after 3 data bits → frame_err pulses 1 cycle, no FIFO write. A following good frame with 0x7E is received correctly.
- Start bit sampled as 0 → frame_err pulse; remaining sclk edges ignored until cs high; FIFO stays empty.
- rst asserted for 1 cycle mid-byte after 4 bits → all outputs 0, FSM IDLE. The next frame with 0xC3 yields rx_data=0xC3 with no error.
